// File: rtl/mcu0_pkg.sv
// rtl/mcu0_pkg.sv - shared types and constants for the mcu0 accumulator CPU
package mcu0_pkg;

  // Fetch sequencer states: idle, waiting for high byte, waiting for low byte
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RD_HI = 2'd1,
    ST_RD_LO = 2'd2
  } fetch_state_e;

  // Opcodes carried in ir[15:12]
  localparam logic [3:0] OP_LD  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_JMP = 4'd2;
  localparam logic [3:0] OP_ST  = 4'd3;
  localparam logic [3:0] OP_CMP = 4'd4;
  localparam logic [3:0] OP_JEQ = 4'd5;

  // Opcode field of an instruction word
  function automatic logic [3:0] ir_op(input logic [15:0] ir);
    return ir[15:12];
  endfunction

  // 12-bit constant/address field of an instruction word
  function automatic logic [11:0] ir_c(input logic [15:0] ir);
    return ir[11:0];
  endfunction

endpackage

// File: rtl/mcu0_fetch_unit_if.sv
// rtl/mcu0_fetch_unit_if.sv - memory, instruction and redirect signals of the fetch unit
interface mcu0_fetch_unit_if #(parameter int AW = 12);
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_ack;
  logic          ir_valid;
  logic          ir_ready;
  logic [15:0]   ir_data;
  logic [AW-1:0] ir_pc;
  logic          redirect;
  logic [AW-1:0] redirect_pc;

  // Fetch unit side
  modport master (
    output mem_rd, mem_addr, ir_valid, ir_data, ir_pc,
    input  mem_rdata, mem_ack, ir_ready, redirect, redirect_pc
  );

  // Memory / decode-execute side
  modport slave (
    input  mem_rd, mem_addr, ir_valid, ir_data, ir_pc,
    output mem_rdata, mem_ack, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/mcu0_ifq.sv
// rtl/mcu0_ifq.sv - small shift-register FIFO of {pc,ir} with registered head
module mcu0_ifq #(
  parameter int W     = 28,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  data_q [DEPTH];
  logic [W-1:0]  data_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic          do_pop, do_push;
  logic [CW-1:0] wr_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign head    = data_q[0];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Slot index after the pop shift has happened
  assign wr_idx  = count_q - CW'(do_pop);

  // Next-state: shift on pop, write behind the last live entry on push; flush wins
  always_comb begin
    count_d = count_q;
    for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];
    if (flush) begin
      count_d = '0;
    end else begin
      if (do_pop) begin
        for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i + 1];
      end
      if (do_push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == wr_idx) data_d[i] = din;
        end
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage and occupancy registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

endmodule

// File: rtl/mcu0_fetch_unit.sv
// rtl/mcu0_fetch_unit.sv - byte-wide instruction fetch sequencer feeding decode/execute
module mcu0_fetch_unit
  import mcu0_pkg::*;
#(
  parameter int            AW       = 12,
  parameter int            DEPTH    = 2,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input logic              clock,
  input logic              reset,
  mcu0_fetch_unit_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_q;
  logic [AW-1:0] fpc_q;
  logic [7:0]    hi_q;
  logic          mem_rd_q;
  logic [AW-1:0] mem_addr_q;

  logic          ack, push, pop;
  logic          q_full, q_empty;
  logic [CW-1:0] q_count;
  logic [CW:0]   post_cnt;
  logic [AW+15:0] q_head;

  // An ack only counts while a read is actually outstanding
  assign ack  = bus.mem_ack & mem_rd_q;
  assign pop  = bus.ir_ready & ~q_empty;
  assign push = (state_q == ST_RD_LO) & ack;
  // Occupancy after this cycle's push, accounting for a simultaneous pop
  assign post_cnt = {1'b0, q_count} + (CW+1)'(1) - (CW+1)'(pop);

  assign bus.mem_rd   = mem_rd_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.ir_valid = ~q_empty;
  assign bus.ir_pc    = q_head[AW+15:16];
  assign bus.ir_data  = q_head[15:0];

  mcu0_ifq #(
    .W     (AW + 16),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_ifq (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .din   ({fpc_q, hi_q, bus.mem_rdata}),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  // Fetch FSM: redirect restarts from IDLE; two byte reads per instruction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fpc_q      <= RESET_PC;
      hi_q       <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= RESET_PC;
    end else if (bus.redirect) begin
      state_q    <= ST_IDLE;
      fpc_q      <= {bus.redirect_pc[AW-1:1], 1'b0};
      mem_rd_q   <= 1'b0;
      mem_addr_q <= {bus.redirect_pc[AW-1:1], 1'b0};
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (q_count < CW'(DEPTH)) begin
            state_q    <= ST_RD_HI;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= fpc_q;
          end
        end
        ST_RD_HI: begin
          if (ack) begin
            hi_q       <= bus.mem_rdata;
            state_q    <= ST_RD_LO;
            mem_addr_q <= fpc_q + AW'(1);
          end
        end
        ST_RD_LO: begin
          if (ack) begin
            fpc_q      <= fpc_q + AW'(2);
            mem_addr_q <= fpc_q + AW'(2);
            if (post_cnt < (CW+1)'(DEPTH)) begin
              state_q <= ST_RD_HI;
            end else begin
              state_q  <= ST_IDLE;
              mem_rd_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          mem_rd_q <= 1'b0;
        end
      endcase
    end
  end

  // q_full is implied by q_count; kept on the FIFO for other users
  logic unused_full;
  assign unused_full = q_full;

endmodule

// File: tb/tb_mcu0_fetch_unit.sv
// tb/tb_mcu0_fetch_unit.sv - self-checking bench for mcu0_fetch_unit
`timescale 1ns/1ps
module tb_mcu0_fetch_unit;
  localparam int            AW       = 12;
  localparam int            DEPTH    = 2;
  localparam logic [AW-1:0] RESET_PC = '0;

  logic clock = 1'b0;
  logic reset = 1'b1;

  mcu0_fetch_unit_if #(.AW(AW)) bus();

  mcu0_fetch_unit #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [7:0] mem [4096];
  int errors = 0;
  int checks = 0;
  int wait_cycles = 0;
  int wcnt = 0;

  // Memory: acks after wait_cycles idle cycles; random junk ack while not reading
  always @(posedge clock) begin
    #2;
    if (bus.mem_rd) begin
      if (wcnt >= wait_cycles) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        wcnt = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 8'($urandom);
        wcnt++;
      end
    end else begin
      bus.mem_ack   = 1'($urandom);
      bus.mem_rdata = 8'($urandom);
      wcnt = 0;
    end
  end

  // Reference stream: consecutive pcs from the last restart point, bytes from mem
  logic [AW-1:0] exp_pc = RESET_PC;
  logic [AW-1:0] exp_lo;
  logic          prev_rd = 1'b0, prev_ack = 1'b0, prev_redir = 1'b0, prev_rst = 1'b1;
  logic [AW-1:0] prev_addr = '0;
  always @(negedge clock) begin
    if (reset) begin
      exp_pc = RESET_PC;
    end else begin
      if (bus.ir_valid && bus.ir_ready) begin
        exp_lo = exp_pc + AW'(1);
        checks++;
        if (bus.ir_pc !== exp_pc || bus.ir_data !== {mem[exp_pc], mem[exp_lo]}) begin
          errors++;
          $display("FAIL sb_pop: got pc=%h ir=%h, expected pc=%h ir=%h",
                   bus.ir_pc, bus.ir_data, exp_pc, {mem[exp_pc], mem[exp_lo]});
        end
        exp_pc = exp_pc + AW'(2);
      end
      if (bus.redirect) exp_pc = {bus.redirect_pc[AW-1:1], 1'b0};
      if (prev_rd && !prev_ack && !prev_redir && !prev_rst) begin
        checks++;
        if (bus.mem_rd !== 1'b1 || bus.mem_addr !== prev_addr) begin
          errors++;
          $display("FAIL stall_hold: got rd=%b addr=%h, expected rd=1 addr=%h",
                   bus.mem_rd, bus.mem_addr, prev_addr);
        end
      end
    end
    prev_rd    = bus.mem_rd;
    prev_ack   = bus.mem_ack;
    prev_addr  = bus.mem_addr;
    prev_redir = bus.redirect;
    prev_rst   = reset;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.mem_addr !== RESET_PC || bus.ir_valid !== 1'b0 ||
        bus.ir_data !== 16'h0 || bus.ir_pc !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rd=%b addr=%h v=%b ir=%h pc=%h, expected 0 %h 0 0000 000",
               bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_data, bus.ir_pc, RESET_PC);
    end
  endtask

  task automatic test_basic();
    wait_cycles = 0;
    bus.ir_ready = 1'b1;
    do_reset();
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h000 || bus.ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge1: got rd=%b addr=%h v=%b, expected 1 000 0", bus.mem_rd, bus.mem_addr, bus.ir_valid);
    end
    tick();
    checks++;
    if (bus.ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_edge2: got valid=%b, expected 0", bus.ir_valid);
    end
    tick();
    checks++;
    if (bus.ir_valid !== 1'b1 || bus.ir_data !== 16'h1000 || bus.ir_pc !== 12'h000) begin
      errors++;
      $display("FAIL basic_first: got v=%b ir=%h pc=%h, expected 1 1000 000", bus.ir_valid, bus.ir_data, bus.ir_pc);
    end
    tick();
    tick();
    checks++;
    if (bus.ir_valid !== 1'b1 || bus.ir_data !== 16'h2004 || bus.ir_pc !== 12'h002) begin
      errors++;
      $display("FAIL basic_second: got v=%b ir=%h pc=%h, expected 1 2004 002", bus.ir_valid, bus.ir_data, bus.ir_pc);
    end
  endtask

  task automatic test_backpressure();
    int pops;
    wait_cycles = 0;
    bus.ir_ready = 1'b0;
    do_reset();
    repeat (12) tick();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (bus.mem_rd !== 1'b0 || bus.ir_valid !== 1'b1 || bus.ir_data !== 16'h1000 || bus.ir_pc !== 12'h000) begin
        errors++;
        $display("FAIL bp_hold: got rd=%b v=%b ir=%h pc=%h, expected 0 1 1000 000",
                 bus.mem_rd, bus.ir_valid, bus.ir_data, bus.ir_pc);
      end
      tick();
    end
    bus.ir_ready = 1'b1;
    pops = 0;
    for (int k = 0; k < 20 && !bus.mem_rd; k++) begin
      if (bus.ir_valid) pops++;
      tick();
    end
    checks++;
    if (pops != DEPTH || bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'(2 * DEPTH)) begin
      errors++;
      $display("FAIL bp_resume: got pops=%0d rd=%b addr=%h, expected %0d 1 %h",
               pops, bus.mem_rd, bus.mem_addr, DEPTH, 12'(2 * DEPTH));
    end
    repeat (10) tick();
  endtask

  task automatic test_stall();
    int stamps[$];
    wait_cycles = 3;
    bus.ir_ready = 1'b1;
    do_reset();
    for (int c = 0; c < 120 && stamps.size() < 3; c++) begin
      if (bus.ir_valid) stamps.push_back(c);
      tick();
    end
    checks++;
    if (stamps.size() != 3) begin
      errors++;
      $display("FAIL stall_timeout: got %0d instructions, expected 3", stamps.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (stamps[i] - stamps[i-1] != 8) begin
          errors++;
          $display("FAIL stall_period: got %0d cycles, expected 8", stamps[i] - stamps[i-1]);
        end
      end
    end
    wait_cycles = 0;
  endtask

  task automatic test_redirect();
    bit found;
    wait_cycles = 0;
    bus.ir_ready = 1'b1;
    do_reset();
    repeat (4) tick();
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (bus.mem_rd && bus.mem_addr[0]) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_find_lo: got no low-byte read, expected one");
    end
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'h00B;
    tick();
    bus.redirect = 1'b0;
    checks++;
    if (bus.ir_valid !== 1'b0 || bus.mem_rd !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: got v=%b rd=%b, expected 0 0", bus.ir_valid, bus.mem_rd);
    end
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.ir_valid) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || bus.ir_pc !== 12'h00A || bus.ir_data !== {mem[12'h00A], mem[12'h00B]}) begin
      errors++;
      $display("FAIL redir_target: got v=%b pc=%h ir=%h, expected 1 00a %h",
               bus.ir_valid, bus.ir_pc, bus.ir_data, {mem[12'h00A], mem[12'h00B]});
    end
  endtask

  task automatic test_wrap();
    bit found;
    wait_cycles = 0;
    bus.ir_ready = 1'b1;
    do_reset();
    repeat (3) tick();
    bus.redirect = 1'b1;
    bus.redirect_pc = 12'hFFE;
    tick();
    bus.redirect = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (bus.mem_rd && bus.mem_addr == 12'hFFF) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wrap_find: got no read of fff, expected one");
    end
    tick();
    checks++;
    if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 12'h000 || bus.ir_valid !== 1'b1 || bus.ir_pc !== 12'hFFE) begin
      errors++;
      $display("FAIL wrap_addr: got rd=%b addr=%h v=%b pc=%h, expected 1 000 1 ffe",
               bus.mem_rd, bus.mem_addr, bus.ir_valid, bus.ir_pc);
    end
    tick();
    tick();
    checks++;
    if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 12'h000 || bus.ir_data !== {mem[0], mem[1]}) begin
      errors++;
      $display("FAIL wrap_next: got v=%b pc=%h ir=%h, expected 1 000 %h",
               bus.ir_valid, bus.ir_pc, bus.ir_data, {mem[0], mem[1]});
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    wait_cycles = 3;
    bus.ir_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.mem_rd && bus.mem_addr == 12'h002) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || bus.ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL rmid_setup: got found=%b v=%b, expected 1 1", found, bus.ir_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.mem_rd !== 1'b0 || bus.ir_valid !== 1'b0 || bus.mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rmid_async: got rd=%b v=%b addr=%h, expected 0 0 %h",
               bus.mem_rd, bus.ir_valid, bus.mem_addr, RESET_PC);
    end
    tick();
    reset = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      if (bus.mem_rd) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found || bus.mem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rmid_refetch: got rd=%b addr=%h, expected 1 %h", bus.mem_rd, bus.mem_addr, RESET_PC);
    end
    bus.ir_ready = 1'b1;
    repeat (20) tick();
    wait_cycles = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0) wait_cycles = $urandom_range(0, 2);
      bus.ir_ready = ($urandom_range(0, 3) != 0);
      bus.redirect = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = 12'($urandom);
      tick();
    end
    bus.redirect = 1'b0;
    bus.ir_ready = 1'b1;
    wait_cycles = 0;
    repeat (10) tick();
  endtask

  initial begin
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h10;
    mem[1] = 8'h00;
    mem[2] = 8'h20;
    mem[3] = 8'h04;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
